// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared width constant for the datapath adder
package add_pkg;
  localparam int ADD_WIDTH = 64;
endpackage

// File: rtl/add_full_adder.sv
// rtl/add_full_adder.sv - one-bit full adder cell for the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add.sv
// rtl/add.sv - registered unsigned ripple-carry adder with carry-out
module add
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  // No carry-in port: the chain always starts from zero.
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y    <= '0;
      cout <= 1'b0;
    end else begin
      Y    <= sum;
      cout <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_add.sv
// tb/tb_add.sv - self-checking bench for the registered 64-bit adder
module tb_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] A;
  logic [63:0] B;
  logic [63:0] Y;
  logic        cout;

  int checks = 0;
  int errors = 0;

  add #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Y     (Y),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply operands for one edge and compare against plain 65-bit arithmetic.
  task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] exp;
    A = a;
    B = b;
    exp = {1'b0, a} + {1'b0, b};
    @(posedge clk);
    #1;
    check(tag, {cout, Y}, exp);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    int          rand_errs_before;

    rst_n = 1'b0;
    A = '1;
    B = '1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {cout, Y}, 65'd0);

    rst_n = 1'b1;
    step("msb_carry", 64'hC000_0000_0000_0003, 64'h8000_0000_0000_0001);
    check("msb_carry_const", {cout, Y}, {1'b1, 64'h4000_0000_0000_0004});

    step("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
    check("full_ripple_const", {cout, Y}, {1'b1, 64'h0});

    step("no_carry", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    check("no_carry_const", {cout, Y}, {1'b0, 64'h1234_5678_9ABC_DF00});
    step("latency_zero", 64'h0, 64'h0);
    check("latency_zero_const", {cout, Y}, 65'd0);

    A = 64'h8000_0000_0000_0000;
    B = 64'h8000_0000_0000_0000;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midstream_reset", {cout, Y}, 65'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", {cout, Y}, {1'b1, 64'h0});

    step("max_plus_max", '1, '1);

    rand_errs_before = errors;
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      step("random", ra, rb);
      if (errors - rand_errs_before > 20) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
